music_view_pager: RTL and testbench

- Parametrised successor to the fixed 4-track note viewer.
- Shows NUM_TRACKS note codes on the EGO1 8-digit tube, 4 tracks per page. Each track uses 2 digits: scale degree and octave.
- Pages auto-rotate on a timer. An internal scan counter time-multiplexes the digits.
- Drives the 16 LEDs as per-track activity bars, with a blink on each note change. Sits between the track sequencer and the board pins.

---
 rtl/music_view_pkg.sv | 30 +++
 rtl/music_note_seg.sv | 36 +++
 rtl/music_view_pager.sv | 152 +++++++++++++++
 tb/tb_music_view_pager.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/music_view_pkg.sv
// Shared constants, types and helpers for the paged note viewer.
package music_view_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned NUM_DIGITS = 8;

  localparam int unsigned NOTE_REST = 0;
  localparam int unsigned NOTE_MAX  = 35;
  localparam int unsigned DEGREES   = 7;

  // Seven-segment patterns: bit0=a .. bit6=g, bit7=dp, active-high.
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  // Degree and octave digit patterns for one track slot.
  typedef struct packed {
    logic [7:0] deg;
    logic [7:0] oct;
  } slot_seg_t;

  // Number of 4-track pages needed for n tracks.
  function automatic int unsigned ceil_div4(input int unsigned n);
    return (n + 3) / 4;
  endfunction

endpackage

// File: rtl/music_note_seg.sv
// Combinational note code to {degree, octave} seven-segment converter.
module music_note_seg
  import music_view_pkg::*;
#(
  parameter int unsigned NOTE_W = 6
) (
  input  logic [NOTE_W-1:0] note,
  output slot_seg_t         segs_c
);

  logic [7:0] n8;
  logic [7:0] idx;
  logic [3:0] deg_i;
  logic [3:0] oct_i;

  // Rest blanks, out-of-range shows dashes, otherwise degree 1-7 / octave 0-4.
  always_comb begin
    segs_c.deg = SEG_BLANK;
    segs_c.oct = SEG_BLANK;
    n8    = 8'(note);
    idx   = n8 - 8'd1;
    deg_i = 4'(idx % 8'(DEGREES)) + 4'd1;
    oct_i = 4'(idx / 8'(DEGREES));
    if (n8 == 8'(NOTE_REST)) begin
      segs_c.deg = SEG_BLANK;
      segs_c.oct = SEG_BLANK;
    end else if (n8 > 8'(NOTE_MAX)) begin
      segs_c.deg = SEG_DASH;
      segs_c.oct = SEG_DASH;
    end else begin
      segs_c.deg = SEG_DIGIT[deg_i];
      segs_c.oct = SEG_DIGIT[oct_i];
    end
  end

endmodule

// File: rtl/music_view_pager.sv
// Paged NUM_TRACKS note viewer for the EGO1 8-digit tube and 16 LEDs.
// Optional page-indicator decimal point: MUSIC_VIEW_PAGE_DP_EN.
module music_view_pager
  import music_view_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 6,
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned PAGE_DIV   = 200000000,
  parameter int unsigned FLASH_CYC  = 10000000
) (
  input  logic                         EGO1_Clock,
  input  logic                         reset,
  input  logic [NUM_TRACKS*NOTE_W-1:0] tracks,
  input  logic                         page_hold,
  output logic [7:0]                   EGO1_DigitalTubes_Enable,
  output logic [15:0]                  EGO1_DigitalTube,
  output logic [15:0]                  EGO1_Lights
);

  localparam int unsigned NUM_PAGES = ceil_div4(NUM_TRACKS);
  localparam int unsigned PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int unsigned SCAN_TW   = $clog2(SCAN_DIV);
  localparam int unsigned PAGE_TW   = $clog2(PAGE_DIV);
  localparam int unsigned FLASH_W   = $clog2(FLASH_CYC + 1);

  logic [NOTE_W-1:0]  note_q      [NUM_TRACKS];
  logic [NOTE_W-1:0]  note_d      [NUM_TRACKS];
  logic [NOTE_W-1:0]  note_prev_q [NUM_TRACKS];
  logic [NOTE_W-1:0]  note_prev_d [NUM_TRACKS];
  logic [FLASH_W-1:0] flash_q     [NUM_TRACKS];
  logic [FLASH_W-1:0] flash_d     [NUM_TRACKS];

  logic [SCAN_TW-1:0] scan_tmr_q, scan_tmr_d;
  logic [1:0]         scan_pos_q, scan_pos_d;
  logic [PAGE_TW-1:0] page_tmr_q, page_tmr_d;
  logic [PAGE_W-1:0]  page_q, page_d;

  logic [7:0]  en_q, en_d;
  logic [15:0] seg_q, seg_d;
  logic [15:0] lights_q, lights_d;

  logic [NOTE_W-1:0] slot_note_c [NUM_SLOTS];
  logic              slot_lit_c  [NUM_SLOTS];
  slot_seg_t         slot_segs_c [NUM_SLOTS];
  logic [7:0]        digit_c     [NUM_DIGITS];

  // Timers, page rotation, input capture and per-track blink counters.
  always_comb begin
    scan_tmr_d  = scan_tmr_q + SCAN_TW'(1);
    scan_pos_d  = scan_pos_q;
    page_tmr_d  = page_tmr_q;
    page_d      = page_q;
    note_prev_d = note_q;
    if (scan_tmr_q == SCAN_TW'(SCAN_DIV - 1)) begin
      scan_tmr_d = '0;
      scan_pos_d = scan_pos_q + 2'd1;
    end
    if (!page_hold) begin
      page_tmr_d = page_tmr_q + PAGE_TW'(1);
      if (page_tmr_q == PAGE_TW'(PAGE_DIV - 1)) begin
        page_tmr_d = '0;
        if (NUM_PAGES > 1) begin
          page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
        end
      end
    end
    for (int k = 0; k < int'(NUM_TRACKS); k++) begin
      note_d[k] = tracks[k*NOTE_W +: NOTE_W];
      if (note_q[k] != note_prev_q[k]) begin
        flash_d[k] = FLASH_W'(FLASH_CYC);
      end else if (flash_q[k] != '0) begin
        flash_d[k] = flash_q[k] - FLASH_W'(1);
      end else begin
        flash_d[k] = '0;
      end
    end
  end

  // Map each slot of the current page onto its track; absent tracks read as rests.
  always_comb begin
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      slot_note_c[s] = '0;
      slot_lit_c[s]  = 1'b0;
      for (int k = 0; k < int'(NUM_TRACKS); k++) begin
        if (5'(k) == 5'(page_q) * 5'd4 + 5'(s)) begin
          slot_note_c[s] = note_q[k];
          slot_lit_c[s]  = (note_q[k] != NOTE_W'(NOTE_REST)) && (flash_q[k] == '0);
        end
      end
    end
  end

  for (genvar s = 0; s < int'(NUM_SLOTS); s++) begin : g_slot
    music_note_seg #(.NOTE_W(NOTE_W)) u_note_seg (
      .note   (slot_note_c[s]),
      .segs_c (slot_segs_c[s])
    );
  end

  // Lay slot patterns onto the eight digits and pick the scanned pair.
  always_comb begin
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      digit_c[2*s]     = slot_segs_c[s].deg;
      digit_c[2*s + 1] = slot_segs_c[s].oct;
    end
    en_d  = 8'(8'h11 << scan_pos_q);
    seg_d = {digit_c[{1'b0, scan_pos_q}], digit_c[{1'b1, scan_pos_q}]};
`ifdef MUSIC_VIEW_PAGE_DP_EN
    if (3'(page_q) == {1'b0, scan_pos_q}) seg_d[15] = 1'b1;
    if (3'(page_q) == {1'b1, scan_pos_q}) seg_d[7]  = 1'b1;
`endif
    lights_d = '0;
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      lights_d[4*s +: 4] = {4{slot_lit_c[s]}};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge EGO1_Clock) begin
    if (reset) begin
      scan_tmr_q <= '0;
      scan_pos_q <= '0;
      page_tmr_q <= '0;
      page_q     <= '0;
      en_q       <= '0;
      seg_q      <= '0;
      lights_q   <= '0;
      for (int k = 0; k < int'(NUM_TRACKS); k++) begin
        note_q[k]      <= '0;
        note_prev_q[k] <= '0;
        flash_q[k]     <= '0;
      end
    end else begin
      scan_tmr_q  <= scan_tmr_d;
      scan_pos_q  <= scan_pos_d;
      page_tmr_q  <= page_tmr_d;
      page_q      <= page_d;
      en_q        <= en_d;
      seg_q       <= seg_d;
      lights_q    <= lights_d;
      note_q      <= note_d;
      note_prev_q <= note_prev_d;
      flash_q     <= flash_d;
    end
  end

  assign EGO1_DigitalTubes_Enable = en_q;
  assign EGO1_DigitalTube         = seg_q;
  assign EGO1_Lights              = lights_q;

endmodule

// File: tb/tb_music_view_pager.sv
// Scoreboard bench for music_view_pager (NUM_TRACKS=6, SCAN_DIV=4, PAGE_DIV=64, FLASH_CYC=8).
module tb_music_view_pager;

  localparam int unsigned NT = 6;
  localparam int unsigned NW = 6;
`ifdef MUSIC_VIEW_PAGE_DP_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  localparam int F_EN  = 0;
  localparam int F_SEG = 1;
  localparam int F_LT  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NT*NW-1:0] tracks;
  logic           page_hold;
  logic [7:0]     en;
  logic [15:0]    seg;
  logic [15:0]    lights;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit done = 1'b0;

  typedef struct {
    int          cyc;
    int          fld;
    logic [15:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [15:0] act;

  music_view_pager #(
    .NUM_TRACKS(NT), .NOTE_W(NW), .SCAN_DIV(4), .PAGE_DIV(64), .FLASH_CYC(8)
  ) dut (
    .EGO1_Clock               (clk),
    .reset                    (reset),
    .tracks                   (tracks),
    .page_hold                (page_hold),
    .EGO1_DigitalTubes_Enable (en),
    .EGO1_DigitalTube         (seg),
    .EGO1_Lights              (lights)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected tube word for page p scanning position pos (adds page dp if built).
  function automatic logic [15:0] es(input int p, input int pos,
                                     input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] r;
    r = {hi, lo};
    if (DP && p == pos)     r[15] = 1'b1;
    if (DP && p == pos + 4) r[7]  = 1'b1;
    return r;
  endfunction

  task automatic push(input int c, input int f, input logic [15:0] v, input string nm);
    exp_t x;
    x.cyc = c; x.fld = f; x.val = v; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic set_track(input int k, input int v);
    tracks[k*NW +: NW] = NW'(v);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this cycle, then summarise at the end.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.fld)
        F_EN:    act = {8'h00, en};
        F_SEG:   act = seg;
        default: act = lights;
      endcase
      n_tests++;
      if (e.cyc != cyc || act !== e.val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (due %0d): got %h, expected %h", e.nm, cyc, e.cyc, act, e.val);
      end
    end
    if (cyc > 2000) begin
      $display("FAIL watchdog: cycle %0d exceeded", cyc);
      $fatal(1);
    end
    if (done) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s never checked: got none, expected %h at cyc %0d", e.nm, e.val, e.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    reset = 1'b1;
    page_hold = 1'b0;
    tracks = '0;
    set_track(0, 1);
    set_track(1, 9);
    set_track(2, 0);
    set_track(3, 36);
    set_track(4, 35);
    set_track(5, 8);

    // Reset hold, first enable, initial blink, scan dwell on page 0.
    push(1,  F_EN, 16'h0000, "rst_en");
    push(1,  F_SEG, 16'h0000, "rst_seg");
    push(1,  F_LT, 16'h0000, "rst_lt");
    push(3,  F_EN, 16'h0000, "rst_en_end");
    push(3,  F_SEG, 16'h0000, "rst_seg_end");
    push(3,  F_LT, 16'h0000, "rst_lt_end");
    push(4,  F_EN, 16'h0011, "first_en");
    push(4,  F_SEG, es(0, 0, 8'h00, 8'h00), "first_seg");
    push(4,  F_LT, 16'h0000, "first_lt");
    push(5,  F_EN, 16'h0011, "pos0_en");
    push(5,  F_SEG, es(0, 0, 8'h06, 8'h00), "d0_d4");
    push(5,  F_LT, 16'hF0FF, "lt_pre_blink");
    push(6,  F_LT, 16'h0000, "lt_blink_start");
    push(7,  F_EN, 16'h0011, "pos0_hold");
    push(8,  F_EN, 16'h0022, "pos1_en");
    push(8,  F_SEG, es(0, 1, 8'h3F, 8'h00), "d1_d5");
    push(11, F_EN, 16'h0022, "pos1_hold");
    push(12, F_EN, 16'h0044, "pos2_en");
    push(12, F_SEG, es(0, 2, 8'h5B, 8'h40), "d2_d6");
    push(13, F_LT, 16'h0000, "lt_blink_end");
    push(14, F_LT, 16'hF0FF, "lt_relit");
    push(16, F_EN, 16'h0088, "pos3_en");
    push(16, F_SEG, es(0, 2 + 1, 8'h06, 8'h40), "d3_d7");
    wait_cyc(3);
    reset = 1'b0;

    // Page rotation to page 1 and back, then page_hold across a terminal count.
    push(67,  F_EN, 16'h0088, "p0_last_en");
    push(67,  F_SEG, es(0, 3, 8'h06, 8'h40), "p0_last_seg");
    push(68,  F_EN, 16'h0011, "p1_first_en");
    push(68,  F_SEG, es(1, 0, 8'h07, 8'h00), "p1_t4_deg");
    push(68,  F_LT, 16'h00FF, "p1_lt");
    push(72,  F_SEG, es(1, 1, 8'h66, 8'h00), "p1_t4_oct");
    push(76,  F_EN, 16'h0044, "p1_pos2_en");
    push(76,  F_SEG, es(1, 2, 8'h06, 8'h00), "p1_t5_deg");
    push(131, F_SEG, es(1, 3, 8'h06, 8'h00), "p1_last_seg");
    push(131, F_LT, 16'h00FF, "p1_last_lt");
    push(132, F_SEG, es(0, 0, 8'h06, 8'h00), "p0_wrap_seg");
    push(132, F_LT, 16'hF0FF, "p0_wrap_lt");
    push(196, F_SEG, es(0, 0, 8'h06, 8'h00), "hold_seg0");
    push(200, F_SEG, es(0, 1, 8'h3F, 8'h00), "hold_seg1");
    push(200, F_LT, 16'hF0FF, "hold_lt");
    push(215, F_SEG, es(0, 0, 8'h06, 8'h00), "resume_p0_seg");
    push(215, F_LT, 16'hF0FF, "resume_p0_lt");
    push(216, F_SEG, es(1, 1, 8'h66, 8'h00), "resume_p1_seg");
    push(216, F_LT, 16'h00FF, "resume_p1_lt");
    push(279, F_SEG, es(1, 0, 8'h07, 8'h00), "p1_end_seg");
    push(280, F_SEG, es(0, 1, 8'h3F, 8'h00), "p0_again_seg");
    wait_cyc(190);
    page_hold = 1'b1;
    wait_cyc(210);
    page_hold = 1'b0;

    // Single note change on track 1: eight dark cycles.
    push(292, F_LT, 16'hF0FF, "blink1_pre");
    push(293, F_LT, 16'hF00F, "blink1_dark_first");
    push(300, F_LT, 16'hF00F, "blink1_dark_last");
    push(301, F_LT, 16'hF0FF, "blink1_relit");
    wait_cyc(290);
    set_track(1, 10);

    // Re-change five cycles in reloads the counter.
    push(312, F_LT, 16'hF0FF, "blink2_pre");
    push(313, F_LT, 16'hF00F, "blink2_dark_first");
    push(321, F_LT, 16'hF00F, "blink2_extended");
    push(325, F_LT, 16'hF00F, "blink2_dark_last");
    push(326, F_LT, 16'hF0FF, "blink2_relit");
    push(332, F_EN, 16'h0044, "t1_12_en");
    push(332, F_SEG, es(0, 2, 8'h6D, 8'h40), "t1_12_deg");
    wait_cyc(310);
    set_track(1, 11);
    wait_cyc(315);
    set_track(1, 12);

    // Reset mid-operation.
    push(335, F_EN, 16'h0000, "mid_rst_en");
    push(335, F_SEG, 16'h0000, "mid_rst_seg");
    push(335, F_LT, 16'h0000, "mid_rst_lt");
    push(336, F_EN, 16'h0000, "mid_rst_en2");
    push(337, F_EN, 16'h0011, "post_rst_en");
    push(337, F_SEG, es(0, 0, 8'h00, 8'h00), "post_rst_seg");
    push(337, F_LT, 16'h0000, "post_rst_lt");
    push(338, F_SEG, es(0, 0, 8'h06, 8'h00), "post_rst_note");
    push(338, F_LT, 16'hF0FF, "post_rst_lit");
    push(339, F_LT, 16'h0000, "post_rst_blink");
    wait_cyc(334);
    reset = 1'b1;
    wait_cyc(336);
    reset = 1'b0;

    wait_cyc(345);
    done = 1'b1;
  end

endmodule
